// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants for the fetch-stage sequencer: next-PC select codes,
// FSM state encoding and the branch-offset helper.
package fetch_pc_ctrl_pkg;

  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_e;

  // Sign-extended 16-bit word offset converted to a byte offset.
  function automatic logic [31:0] sext16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pc_target_calc.sv
// Combinational redirect target for the D-stage branch/jump decision.
// redir_valid is low for NPC_PC4 and unused select codes.
module pc_target_calc
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [2:0]  npc_sel,
  input  logic        d_bjump,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_ra,
  output logic [31:0] target,
  output logic        redir_valid
);

  always_comb begin
    target      = 32'h0;
    redir_valid = 1'b0;
    case (npc_sel)
      NPC_BRANCH: begin
        redir_valid = 1'b1;
        target      = d_bjump ? (d_pc + 32'd4 + sext16_x4(d_imm16)) : (d_pc + 32'd8);
      end
      NPC_JUMP: begin
        redir_valid = 1'b1;
        target      = {d_pc[31:28], d_imm26, 2'b00};
      end
      NPC_JR: begin
        redir_valid = 1'b1;
        target      = {d_ra[31:2], 2'b00};
      end
      default: begin
        redir_valid = 1'b0;
        target      = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: PC register, imem request/response handshake and
// delay-slot redirect. Define FETCH_PERF_CNT_EN to add perf_fetch/perf_stall.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        D_redirect,
  input  logic [2:0]  nPC_Sel,
  input  logic        D_bjump,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
`endif
  output logic        F_valid,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr
);

  // state | meaning
  // IDLE  | one cycle after reset, no request
  // FETCH | imem_req high at F_PC, waiting for grant
  // WAIT  | granted, waiting for response
  // VALID | F_instr presented, consumed on !stall
  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, instr_q, tgt_q, target, next_pc;
  logic        valid_q, pend_q, redir_valid, redir_hit, consume;

  pc_target_calc u_target (
    .npc_sel     (nPC_Sel),
    .d_bjump     (D_bjump),
    .d_pc        (D_PC),
    .d_imm16     (D_imm16),
    .d_imm26     (D_imm26),
    .d_ra        (D_ra),
    .target      (target),
    .redir_valid (redir_valid)
  );

  assign consume   = (state_q == ST_VALID) && !stall;
  assign redir_hit = D_redirect && redir_valid;

  // A redirect arriving in the same cycle as the consume bypasses tgt_q.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (redir_hit)   next_pc = target;
    else if (pend_q) next_pc = tgt_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_gnt)    state_d = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_d = ST_VALID;
      ST_VALID: if (!stall)      state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_WAIT) && imem_rvalid) begin
        instr_q <= imem_rdata;
        valid_q <= 1'b1;
      end
      if (consume) begin
        pc_q    <= next_pc;
        valid_q <= 1'b0;
        pend_q  <= 1'b0;
      end else if (redir_hit) begin
        tgt_q  <= target;
        pend_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (consume)                          perf_fetch_q <= perf_fetch_q + 32'd1;
      if ((state_q == ST_VALID) && stall)   perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign F_valid   = valid_q;
  assign F_PC      = pc_q;
  assign F_instr   = instr_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: handshake latency, stalls, delay-slot
// redirects and reset during an outstanding fetch.
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, stall, D_redirect, D_bjump;
  logic [2:0]  nPC_Sel;
  logic [31:0] D_PC, D_ra, imem_addr, imem_rdata, F_PC, F_instr;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic        imem_req, imem_gnt, imem_rvalid, F_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .D_redirect  (D_redirect),
    .nPC_Sel     (nPC_Sel),
    .D_bjump     (D_bjump),
    .D_PC        (D_PC),
    .D_imm16     (D_imm16),
    .D_imm26     (D_imm26),
    .D_ra        (D_ra),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall),
`endif
    .F_valid     (F_valid),
    .F_PC        (F_PC),
    .F_instr     (F_instr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [2:0] sel, input logic bj, input logic [31:0] pc,
                          input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] ra);
    D_redirect = 1'b1; nPC_Sel = sel; D_bjump = bj;
    D_PC = pc; D_imm16 = i16; D_imm26 = i26; D_ra = ra;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
  endtask

  // Serve one fetch; returns at the negedge where the instruction is presented.
  task automatic mem_fetch(input string tag, input logic [31:0] addr,
                           input logic [31:0] word, input int rdly);
    wait_req(tag);
    check({tag, "_addr"}, imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 1; i < rdly; i++) begin
      check({tag, "_wait_fv"}, {31'd0, F_valid}, 32'd0);
      check({tag, "_wait_req"}, {31'd0, imem_req}, 32'd0);
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check({tag, "_fv"}, {31'd0, F_valid}, 32'd1);
    check({tag, "_instr"}, F_instr, word);
    check({tag, "_pc"}, F_PC, addr);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; D_redirect = 1'b0; D_bjump = 1'b0;
    nPC_Sel = NPC_PC4; D_PC = 32'h0; D_imm16 = 16'h0; D_imm26 = 26'h0; D_ra = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) tick();
    check("rst_pc", F_PC, 32'h0000_3000);
    check("rst_instr", F_instr, 32'h0);
    check("rst_fv", {31'd0, F_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);

    // Reset release: IDLE for one edge, request after the next.
    reset_n = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("lat_req", {31'd0, imem_req}, 32'd1);

    // 1: same-cycle grant, 1-cycle response, sequential PC.
    mem_fetch("t1a", 32'h0000_3000, 32'hA000_0000, 1);
    tick();
    // 2: response three cycles after grant.
    mem_fetch("t2", 32'h0000_3004, 32'hA000_0004, 3);

    // 3: hold for 4 stall cycles in VALID.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_pc", F_PC, 32'h0000_3004);
      check("t3_instr", F_instr, 32'hA000_0004);
      check("t3_fv", {31'd0, F_valid}, 32'd1);
      check("t3_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("t3_req_after", {31'd0, imem_req}, 32'd1);
    mem_fetch("t3b", 32'h0000_3008, 32'hA000_0008, 1);
    tick();

    // 4: jump resolved while delay slot is being fetched.
    redirect(NPC_JUMP, 1'b0, 32'h0000_3008, 16'h0, 26'h000_0C10, 32'h0);
    tick();
    D_redirect = 1'b0;
    mem_fetch("t4_slot", 32'h0000_300C, 32'hA000_000C, 1);
    tick();
    mem_fetch("t4_tgt", 32'h0000_3040, 32'hA000_0040, 1);

    // 6: JR coincident with consume, low bits forced to zero.
    redirect(NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3103);
    tick();
    D_redirect = 1'b0;
    mem_fetch("t6", 32'h0000_3100, 32'hA000_0100, 1);
    redirect(NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3013);
    tick();
    D_redirect = 1'b0;
    mem_fetch("t6b", 32'h0000_3010, 32'hA000_0010, 1);
    tick();

    // 5: taken branch with negative offset.
    redirect(NPC_BRANCH, 1'b1, 32'h0000_3010, 16'hFFFC, 26'h0, 32'h0);
    tick();
    D_redirect = 1'b0;
    mem_fetch("t5_slot", 32'h0000_3014, 32'hA000_0014, 1);
    tick();
    mem_fetch("t5_tgt", 32'h0000_3004, 32'hB000_0004, 1);

    // Redirect during a stall is held in tgt_q until consume.
    stall = 1'b1;
    redirect(NPC_JUMP, 1'b0, 32'h0000_3000, 16'h0, 26'h000_0C40, 32'h0);
    tick();
    D_redirect = 1'b0;
    tick();
    check("st_redir_pc", F_PC, 32'h0000_3004);
    stall = 1'b0;
    tick();
    mem_fetch("st_redir", 32'h0000_3100, 32'hB000_0100, 1);
    tick();

    // NPC_PC4 pulse is ignored.
    redirect(NPC_PC4, 1'b1, 32'h0000_3000, 16'h0010, 26'h0, 32'h0);
    tick();
    D_redirect = 1'b0;
    mem_fetch("pc4_a", 32'h0000_3104, 32'hB000_0104, 1);
    tick();
    mem_fetch("pc4_b", 32'h0000_3108, 32'hB000_0108, 1);

    // Not-taken branch, coincident with consume: D_PC+8.
    redirect(NPC_BRANCH, 1'b0, 32'h0000_3200, 16'h0040, 26'h0, 32'h0);
    tick();
    D_redirect = 1'b0;
    mem_fetch("nt", 32'h0000_3208, 32'hB000_0208, 1);
    tick();

    // 7: reset during WAIT with a pending target; stale response in FETCH.
    redirect(NPC_JUMP, 1'b0, 32'h0000_3000, 16'h0, 26'h000_0C80, 32'h0);
    tick();
    D_redirect = 1'b0;
    check("t7_addr", imem_addr, 32'h0000_320C);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset_n = 1'b0;
    tick();
    check("t7_rst_fv", {31'd0, F_valid}, 32'd0);
    check("t7_rst_req", {31'd0, imem_req}, 32'd0);
    check("t7_rst_pc", F_PC, 32'h0000_3000);
    reset_n = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("t7_stale_fv", {31'd0, F_valid}, 32'd0);
    check("t7_stale_instr", F_instr, 32'h0);
    check("t7_stale_req", {31'd0, imem_req}, 32'd1);
    check("t7_stale_addr", imem_addr, 32'h0000_3000);
    mem_fetch("t7a", 32'h0000_3000, 32'hC000_0000, 1);
    tick();
    mem_fetch("t7b", 32'h0000_3004, 32'hC000_0004, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
